// File: rtl/bus_dispatcher.sv
// bus_dispatcher: round-robin token arbiter for the shared external bus, servicing bridge reads/writes on one memory port.
// Optional grant-acknowledge timeout enabled by defining DISP_GRANT_TIMEOUT_EN.
`ifndef CPU_ACTIVE
`define CPU_ACTIVE 32'h8000_0000
`endif
`ifndef CPU_NONACTIVE
`define CPU_NONACTIVE 32'h4000_0000
`endif
`ifndef CPU_R_START
`define CPU_R_START 8'h01
`endif
`ifndef CPU_R_END
`define CPU_R_END 8'h02
`endif

module bus_dispatcher #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_CPUS = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_q,
  output logic              next_cpu_q,
  output logic [DATA_W-1:0] cpu_index,
  input  logic              next_cpu_e,
  input  logic [7:0]        cpu_msg,
  input  logic              read_q,
  input  logic              write_q,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [4:0]        cpu_cnt
);
  typedef enum logic [2:0] {IDLE, POLL, WAIT_E, MEM_RD, MEM_WR, DONE, NEXT} state_t;
  state_t     state_q;
  logic [4:0] slot_q;
  logic [4:0] slot_d;
  logic       adm_slot;
  logic [4:0] cnt_inc;
  logic [4:0] cnt_dec;
`ifdef DISP_GRANT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
`endif

  function automatic logic [DATA_W-1:0] idx_of(input logic [4:0] s, input logic [4:0] c);
    return (s == c) ? DATA_W'(`CPU_NONACTIVE) : (DATA_W'(`CPU_ACTIVE) | DATA_W'(s));
  endfunction

  assign adm_slot = slot_q == cpu_cnt;
  assign cnt_inc  = (cpu_cnt >= 5'(MAX_CPUS)) ? cpu_cnt : cpu_cnt + 5'd1;
  assign cnt_dec  = (cpu_cnt == 5'd0) ? cpu_cnt : cpu_cnt - 5'd1;
  // The admission slot always closes the rotation, even when it just grew the count.
  assign slot_d   = (cpu_index == DATA_W'(`CPU_NONACTIVE) || slot_q >= cpu_cnt) ? 5'd0 : slot_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      cpu_cnt    <= '0;
      next_cpu_q <= 1'b0;
      cpu_index  <= '0;
      data_out   <= '0;
      read_dn    <= 1'b0;
      write_dn   <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
`ifdef DISP_GRANT_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      read_dn  <= 1'b0;
      write_dn <= 1'b0;
      case (state_q)
        IDLE: if (disp_q) begin
          state_q    <= POLL;
          next_cpu_q <= 1'b1;
          cpu_index  <= idx_of(slot_q, cpu_cnt);
`ifdef DISP_GRANT_TIMEOUT_EN
          tmo_q      <= '0;
`endif
        end
        POLL: state_q <= WAIT_E;
        WAIT_E: if (next_cpu_e) begin
          next_cpu_q <= 1'b0;
          if (read_q) begin
            state_q  <= MEM_RD;
            mem_rd   <= 1'b1;
            mem_addr <= addr_in;
          end else if (write_q) begin
            state_q   <= MEM_WR;
            mem_wr    <= 1'b1;
            mem_addr  <= addr_in;
            mem_wdata <= data_in;
          end else begin
            state_q <= NEXT;
            if (cpu_msg == `CPU_R_START && adm_slot) cpu_cnt <= cnt_inc;
            else if (cpu_msg == `CPU_R_END && !adm_slot) cpu_cnt <= cnt_dec;
          end
        end
`ifdef DISP_GRANT_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_q    <= NEXT;
          next_cpu_q <= 1'b0;
        end else tmo_q <= tmo_q + 1'b1;
`endif
        MEM_RD: if (mem_ack) begin
          state_q  <= DONE;
          mem_rd   <= 1'b0;
          data_out <= mem_rdata;
          read_dn  <= 1'b1;
        end
        MEM_WR: if (mem_ack) begin
          state_q  <= DONE;
          mem_wr   <= 1'b0;
          write_dn <= 1'b1;
        end
        DONE: state_q <= NEXT;
        NEXT: begin
          slot_q <= slot_d;
          if (disp_q) begin
            state_q    <= POLL;
            next_cpu_q <= 1'b1;
            cpu_index  <= idx_of(slot_d, cpu_cnt);
`ifdef DISP_GRANT_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end else state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_dispatcher.sv
// tb_bus_dispatcher: directed checks of token rotation, memory servicing, CPU counting, reset and grant waiting.
`ifndef CPU_ACTIVE
`define CPU_ACTIVE 32'h8000_0000
`endif
`ifndef CPU_NONACTIVE
`define CPU_NONACTIVE 32'h4000_0000
`endif
`ifndef CPU_R_START
`define CPU_R_START 8'h01
`endif
`ifndef CPU_R_END
`define CPU_R_END 8'h02
`endif

module tb_bus_dispatcher;
  localparam logic [31:0] ACT = `CPU_ACTIVE;
  localparam logic [31:0] NON = `CPU_NONACTIVE;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disp_q = 1'b0, next_cpu_e = 1'b0, read_q = 1'b0, write_q = 1'b0, mem_ack = 1'b0;
  logic [7:0] cpu_msg = '0;
  logic [31:0] addr_in = '0, data_in = '0, mem_rdata = '0;
  logic next_cpu_q, read_dn, write_dn, mem_rd, mem_wr;
  logic [31:0] cpu_index, data_out, mem_addr, mem_wdata;
  logic [4:0] cpu_cnt;
  int errors = 0;
  int checks = 0;
  int n;
  int bad_idx;

  always #5 clk = ~clk;

  bus_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .disp_q(disp_q), .next_cpu_q(next_cpu_q), .cpu_index(cpu_index),
    .next_cpu_e(next_cpu_e), .cpu_msg(cpu_msg), .read_q(read_q), .write_q(write_q),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .read_dn(read_dn),
    .write_dn(write_dn), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .cpu_cnt(cpu_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // From a POLL cycle: grant with a message only, land on the following POLL.
  task automatic grant_msg(input logic [7:0] m);
    next_cpu_e = 1'b1;
    cpu_msg = m;
    step(2);
    next_cpu_e = 1'b0;
    cpu_msg = '0;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_next_cpu_q", next_cpu_q, 0);
    chk("rst_cpu_index", cpu_index, 0);
    chk("rst_cpu_cnt", cpu_cnt, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_data_out", data_out, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_token", next_cpu_q, 0);

    disp_q = 1'b1;
    step(1);
    chk("poll_token", next_cpu_q, 1);
    chk("poll_admission_idx", cpu_index, NON);
    next_cpu_e = 1'b1;
    cpu_msg = `CPU_R_START;
    step(1);
    chk("wait_token_held", next_cpu_q, 1);
    step(1);
    chk("next_token_low", next_cpu_q, 0);
    chk("start_cnt1", cpu_cnt, 1);
    next_cpu_e = 1'b0;
    cpu_msg = '0;
    step(1);
    chk("after_start_idx", cpu_index, ACT | 32'd0);

    grant_msg(8'h00);
    chk("slot1_admission", cpu_index, NON);
    grant_msg(`CPU_R_START);
    chk("cnt2", cpu_cnt, 2);
    chk("wrap_after_admit", cpu_index, ACT | 32'd0);
    grant_msg(8'h00);
    chk("slot1_active", cpu_index, ACT | 32'd1);

    next_cpu_e = 1'b1;
    read_q = 1'b1;
    addr_in = 32'h100;
    mem_rdata = 32'hDEADBEEF;
    step(2);
    next_cpu_e = 1'b0;
    read_q = 1'b0;
    chk("rd_c1", mem_rd, 1);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_token_low", next_cpu_q, 0);
    step(1);
    chk("rd_c2", mem_rd, 1);
    step(1);
    chk("rd_c3", mem_rd, 1);
    chk("rd_no_dn_yet", read_dn, 0);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("rd_done_strobe_off", mem_rd, 0);
    chk("rd_dn", read_dn, 1);
    chk("rd_data", data_out, 32'hDEADBEEF);
    step(1);
    chk("rd_dn_pulse", read_dn, 0);
    step(1);
    chk("after_rd_idx", cpu_index, NON);

    next_cpu_e = 1'b1;
    write_q = 1'b1;
    addr_in = 32'h20;
    data_in = 32'h12345678;
    step(2);
    next_cpu_e = 1'b0;
    write_q = 1'b0;
    chk("wr_strobe", mem_wr, 1);
    chk("wr_no_rd", mem_rd, 0);
    chk("wr_addr", mem_addr, 32'h20);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("wr_dn", write_dn, 1);
    chk("wr_strobe_off", mem_wr, 0);
    chk("wr_data_out_kept", data_out, 32'hDEADBEEF);
    step(1);
    chk("wr_dn_pulse", write_dn, 0);
    step(1);
    chk("after_wr_wrap", cpu_index, ACT | 32'd0);

    next_cpu_e = 1'b1;
    read_q = 1'b1;
    write_q = 1'b1;
    addr_in = 32'h44;
    mem_rdata = 32'h0BADF00D;
    step(2);
    next_cpu_e = 1'b0;
    read_q = 1'b0;
    write_q = 1'b0;
    chk("both_rd", mem_rd, 1);
    chk("both_no_wr", mem_wr, 0);
    chk("both_addr", mem_addr, 32'h44);
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    chk("both_rd_dn", read_dn, 1);
    chk("both_no_wr_dn", write_dn, 0);
    chk("both_data", data_out, 32'h0BADF00D);
    step(2);
    chk("slot1_again", cpu_index, ACT | 32'd1);

    grant_msg(8'h00);
    grant_msg(`CPU_R_START);
    chk("cnt3", cpu_cnt, 3);
    grant_msg(8'h00);
    grant_msg(8'h00);
    chk("slot2_active", cpu_index, ACT | 32'd2);
    grant_msg(`CPU_R_END);
    chk("end_cnt2", cpu_cnt, 2);
    chk("end_wrap", cpu_index, ACT | 32'd0);

    bad_idx = 0;
    for (int i = 0; i < 200; i++) begin
      grant_msg(`CPU_R_START);
      if (!(cpu_index == NON || (cpu_index[31] && cpu_index[30:0] < 31'(cpu_cnt)))) bad_idx++;
    end
    chk("sat_cnt", cpu_cnt, 16);
    chk("idx_in_range", bad_idx, 0);

    next_cpu_e = 1'b1;
    read_q = 1'b1;
    addr_in = 32'h300;
    step(2);
    next_cpu_e = 1'b0;
    read_q = 1'b0;
    chk("pre_rst_rd", mem_rd, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_mem_rd", mem_rd, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_cnt", cpu_cnt, 0);
    chk("async_idx", cpu_index, 0);
    chk("async_data_out", data_out, 0);
    disp_q = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_idle", next_cpu_q, 0);
    disp_q = 1'b1;
    step(1);
    chk("post_rst_poll_idx", cpu_index, NON);

    n = 0;
    while (next_cpu_q && n < 120) begin
      step(1);
      n++;
    end
`ifdef DISP_GRANT_TIMEOUT_EN
    chk("timeout_cycles", n, 16);
    chk("timeout_cnt", cpu_cnt, 0);
    step(1);
    chk("timeout_repoll", cpu_index, NON);
`else
    chk("no_timeout_hold", n, 120);
    chk("no_timeout_idx", cpu_index, NON);
    chk("no_timeout_cnt", cpu_cnt, 0);
`endif
    disp_q = 1'b0;
    next_cpu_e = 1'b1;
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
